// File: rtl/arm_pipe_pkg.sv
// Shared definitions for the ARMv4 pipeline stages:
// interlock state encoding, control-bundle width and register-number width.
package arm_pipe_pkg;

    localparam int CTRL_W_DEF = 32;
    localparam int REG_W      = 4;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        LWAIT = 1'b1
    } lstate_t;

endpackage

// File: rtl/id_ex_stage_src_match.sv
// src_match: asserts o_match when any source operand that the decode
// instruction actually reads names register i_rnum.
//   i_rm/rn/rs_code : source register numbers
//   i_rm/rn/rs_use  : source is read
//   i_rnum          : register number to compare against
//   o_match         : some used source equals i_rnum
module src_match
    import arm_pipe_pkg::*;
(
    input  logic [REG_W-1:0] i_rm_code,
    input  logic [REG_W-1:0] i_rn_code,
    input  logic [REG_W-1:0] i_rs_code,
    input  logic             i_rm_use,
    input  logic             i_rn_use,
    input  logic             i_rs_use,
    input  logic [REG_W-1:0] i_rnum,
    output logic             o_match
);

    assign o_match = (i_rm_use & (i_rm_code == i_rnum))
                   | (i_rn_use & (i_rn_code == i_rnum))
                   | (i_rs_use & (i_rs_code == i_rnum));

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with valid/ready handshake on both
// sides and an optional load-use interlock (macro LOAD_INTERLOCK_EN).
//   i_clk, i_rst            : clock, synchronous active-high reset
//   i_id_valid / o_id_ready : decode-side handshake
//   i_r*_code/use/reg       : forwarded source operands from decode
//   i_rd_en/code, i_is_load : destination and load flag
//   i_ctrl                  : opaque decoded control bundle
//   i_flush                 : kill the EX slot (branch / exception)
//   o_ex_valid / i_ex_ready : execute-side handshake
//   o_r*_reg, o_rd_*, o_is_load, o_ctrl : registered EX-slot contents
//   o_stall_load            : decode held by the load-use interlock
// LOAD_INTERLOCK_EN undefined: loads behave like ALU ops, no interlock.
module id_ex_stage
    import arm_pipe_pkg::*;
#(
    parameter int CTRL_W   = CTRL_W_DEF,
    parameter int LOAD_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_id_valid,
    output logic              o_id_ready,
    input  logic [REG_W-1:0]  i_rm_code,
    input  logic [REG_W-1:0]  i_rn_code,
    input  logic [REG_W-1:0]  i_rs_code,
    input  logic              i_rm_use,
    input  logic              i_rn_use,
    input  logic              i_rs_use,
    input  logic [31:0]       i_rm_reg,
    input  logic [31:0]       i_rn_reg,
    input  logic [31:0]       i_rs_reg,
    input  logic              i_rd_en,
    input  logic [REG_W-1:0]  i_rd_code,
    input  logic              i_is_load,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic              i_flush,
    output logic              o_ex_valid,
    input  logic              i_ex_ready,
    output logic [31:0]       o_rm_reg,
    output logic [31:0]       o_rn_reg,
    output logic [31:0]       o_rs_reg,
    output logic              o_rd_en,
    output logic [REG_W-1:0]  o_rd_code,
    output logic              o_is_load,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic              o_stall_load
);

    if (LOAD_LAT < 1 || LOAD_LAT > 3) begin : g_bad_lat
        $error("id_ex_stage: LOAD_LAT must be 1..3");
    end

    logic              r_ex_valid;
    logic [31:0]       r_rm_reg;
    logic [31:0]       r_rn_reg;
    logic [31:0]       r_rs_reg;
    logic              r_rd_en;
    logic [REG_W-1:0]  r_rd_code;
    logic              r_is_load;
    logic [CTRL_W-1:0] r_ctrl;

    logic w_ex_free;
    logic w_id_ready;
    logic w_accept;

    assign w_ex_free = ~r_ex_valid | i_ex_ready;
    assign w_accept  = i_id_valid & w_id_ready & ~i_flush;

`ifdef LOAD_INTERLOCK_EN
    lstate_t          r_state;
    logic [1:0]       r_cnt;
    logic [REG_W-1:0] r_lw_rd;

    logic w_hit_rd;
    logic w_hit_lw;
    logic w_hazard;

    src_match u_match_rd (
        .i_rm_code (i_rm_code),
        .i_rn_code (i_rn_code),
        .i_rs_code (i_rs_code),
        .i_rm_use  (i_rm_use),
        .i_rn_use  (i_rn_use),
        .i_rs_use  (i_rs_use),
        .i_rnum    (r_rd_code),
        .o_match   (w_hit_rd)
    );

    src_match u_match_lw (
        .i_rm_code (i_rm_code),
        .i_rn_code (i_rn_code),
        .i_rs_code (i_rs_code),
        .i_rm_use  (i_rm_use),
        .i_rn_use  (i_rn_use),
        .i_rs_use  (i_rs_use),
        .i_rnum    (r_lw_rd),
        .o_match   (w_hit_lw)
    );

    // A load sitting in EX has no forwardable result yet.
    assign w_hazard = r_ex_valid & r_is_load & r_rd_en & w_hit_rd;

    always_comb begin
        w_id_ready = w_ex_free & ~w_hazard;
        if (r_state == LWAIT) begin
            w_id_ready = w_id_ready & ~w_hit_lw;
        end
    end

    assign o_stall_load = i_id_valid & ~w_id_ready & w_ex_free;

    // After the load leaves EX, cnt tracks the remaining cycles until its
    // data is forwardable from WB; it only advances when execute moves.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= RUN;
            r_cnt   <= 2'd0;
            r_lw_rd <= '0;
        end else if (i_flush) begin
            r_state <= RUN;
            r_cnt   <= 2'd0;
        end else begin
            unique case (r_state)
                RUN: begin
                    if (w_hazard && w_ex_free) begin
                        r_lw_rd <= r_rd_code;
                        if (LOAD_LAT > 1) begin
                            r_cnt   <= 2'(LOAD_LAT - 1);
                            r_state <= LWAIT;
                        end
                    end
                end
                LWAIT: begin
                    if (i_ex_ready) begin
                        if (r_cnt <= 2'd1) begin
                            r_cnt   <= 2'd0;
                            r_state <= RUN;
                        end else begin
                            r_cnt <= r_cnt - 2'd1;
                        end
                    end
                end
                default: r_state <= RUN;
            endcase
        end
    end
`else
    logic w_unused;

    // Source fields only feed the interlock, which is absent here.
    assign w_unused = ^{i_rm_code, i_rn_code, i_rs_code,
                        i_rm_use, i_rn_use, i_rs_use};

    assign w_id_ready   = w_ex_free;
    assign o_stall_load = 1'b0;
`endif

    // Data fields only change on accept; a bubble clears just the valid.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ex_valid <= 1'b0;
            r_rm_reg   <= '0;
            r_rn_reg   <= '0;
            r_rs_reg   <= '0;
            r_rd_en    <= 1'b0;
            r_rd_code  <= '0;
            r_is_load  <= 1'b0;
            r_ctrl     <= '0;
        end else if (i_flush) begin
            r_ex_valid <= 1'b0;
        end else if (w_accept) begin
            r_ex_valid <= 1'b1;
            r_rm_reg   <= i_rm_reg;
            r_rn_reg   <= i_rn_reg;
            r_rs_reg   <= i_rs_reg;
            r_rd_en    <= i_rd_en;
            r_rd_code  <= i_rd_code;
            r_is_load  <= i_is_load;
            r_ctrl     <= i_ctrl;
        end else if (w_ex_free) begin
            r_ex_valid <= 1'b0;
        end
    end

    assign o_id_ready = w_id_ready;
    assign o_ex_valid = r_ex_valid;
    assign o_rm_reg   = r_rm_reg;
    assign o_rn_reg   = r_rn_reg;
    assign o_rs_reg   = r_rs_reg;
    assign o_rd_en    = r_rd_en;
    assign o_rd_code  = r_rd_code;
    assign o_is_load  = r_is_load;
    assign o_ctrl     = r_ctrl;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: instance 0 LOAD_LAT=1, instance 1 LOAD_LAT=3.
// Data inputs are shared; each instance has its own decode valid.
module tb_id_ex_stage;

`ifdef LOAD_INTERLOCK_EN
    localparam bit IL = 1'b1;
`else
    localparam bit IL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        v1, v3;
    logic [3:0]  rmc, rnc, rsc, rdc;
    logic        rmu, rnu, rsu, rde, ld;
    logic [31:0] rmv, rnv, rsv, ctrl;
    logic        flush, exr;

    logic        exv [2];
    logic        rdy [2];
    logic        stl [2];
    logic        rdeo [2];
    logic        ldo [2];
    logic [31:0] rmo [2];
    logic [31:0] rno [2];
    logic [31:0] rso [2];
    logic [31:0] ctlo [2];
    logic [3:0]  rdco [2];

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        id_ex_stage #(
            .CTRL_W   (32),
            .LOAD_LAT (g == 0 ? 1 : 3)
        ) u_dut (
            .i_clk        (clk),
            .i_rst        (rst),
            .i_id_valid   (g == 0 ? v1 : v3),
            .o_id_ready   (rdy[g]),
            .i_rm_code    (rmc),
            .i_rn_code    (rnc),
            .i_rs_code    (rsc),
            .i_rm_use     (rmu),
            .i_rn_use     (rnu),
            .i_rs_use     (rsu),
            .i_rm_reg     (rmv),
            .i_rn_reg     (rnv),
            .i_rs_reg     (rsv),
            .i_rd_en      (rde),
            .i_rd_code    (rdc),
            .i_is_load    (ld),
            .i_ctrl       (ctrl),
            .i_flush      (flush),
            .o_ex_valid   (exv[g]),
            .i_ex_ready   (exr),
            .o_rm_reg     (rmo[g]),
            .o_rn_reg     (rno[g]),
            .o_rs_reg     (rso[g]),
            .o_rd_en      (rdeo[g]),
            .o_rd_code    (rdco[g]),
            .o_is_load    (ldo[g]),
            .o_ctrl       (ctlo[g]),
            .o_stall_load (stl[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [3:0] a_c, input logic [3:0] b_c,
                      input logic [3:0] c_c, input logic [2:0] u,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] c, input logic [3:0] rd,
                      input logic load);
        rmc = a_c;
        rnc = b_c;
        rsc = c_c;
        {rmu, rnu, rsu} = u;
        rmv = a;
        rnv = b;
        rsv = c;
        rde = 1'b1;
        rdc = rd;
        ld = load;
        ctrl = a ^ b ^ 32'hC0DE_0000;
    endtask

    logic [31:0] ta [3] = '{32'h11, 32'h44, 32'h77};
    logic [31:0] tb [3] = '{32'h22, 32'h55, 32'h88};
    logic [31:0] tc [3] = '{32'h33, 32'h66, 32'h99};

    initial begin
        rst = 1'b1;
        v1 = 1'b0;
        v3 = 1'b0;
        flush = 1'b0;
        exr = 1'b1;
        op(4'd0, 4'd0, 4'd0, 3'b000, 32'h0, 32'h0, 32'h0, 4'd0, 1'b0);
        rde = 1'b0;
        tick();
        tick();
        for (int g = 0; g < 2; g++) begin
            chk("rst_exv", 32'(exv[g]), 32'd0);
            chk("rst_rm", rmo[g], 32'd0);
            chk("rst_ctrl", ctlo[g], 32'd0);
            chk("rst_ld", 32'(ldo[g]), 32'd0);
        end
        rst = 1'b0;
        #1;
        chk("rst_rdy", 32'(rdy[1]), 32'd1);
        chk("rst_stl", 32'(stl[1]), 32'd0);

        // back-to-back ALU ops
        for (int i = 0; i < 3; i++) begin
            v3 = 1'b1;
            op(4'd1, 4'd2, 4'd4, 3'b111, ta[i], tb[i], tc[i],
               4'(6 + i), 1'b0);
            #1;
            chk("b2b_rdy", 32'(rdy[1]), 32'd1);
            tick();
            chk("b2b_exv", 32'(exv[1]), 32'd1);
            chk("b2b_rm", rmo[1], ta[i]);
            chk("b2b_rn", rno[1], tb[i]);
            chk("b2b_rs", rso[1], tc[i]);
            chk("b2b_rd", 32'(rdco[1]), 32'(6 + i));
            chk("b2b_ctrl", ctlo[1], ta[i] ^ tb[i] ^ 32'hC0DE_0000);
        end

        // execute stall holds the slot
        op(4'd1, 4'd2, 4'd4, 3'b111, 32'hDEAD_BEEF, 32'h1, 32'h2,
           4'd9, 1'b0);
        #1;
        tick();
        chk("stall_load_rm", rmo[1], 32'hDEAD_BEEF);
        exr = 1'b0;
        op(4'd5, 4'd6, 4'd7, 3'b111, 32'h1234, 32'h5678, 32'h9ABC,
           4'd10, 1'b0);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("hold_rdy", 32'(rdy[1]), 32'd0);
            chk("hold_stl", 32'(stl[1]), 32'd0);
            tick();
            chk("hold_exv", 32'(exv[1]), 32'd1);
            chk("hold_rm", rmo[1], 32'hDEAD_BEEF);
        end
        exr = 1'b1;
        #1;
        chk("rel_rdy", 32'(rdy[1]), 32'd1);
        tick();
        chk("rel_rm", rmo[1], 32'h1234);
        chk("rel_rd", 32'(rdco[1]), 32'd10);
        v3 = 1'b0;
        #1;
        tick();
        chk("bub_exv", 32'(exv[1]), 32'd0);
        chk("bub_rm", rmo[1], 32'h1234);

        // load-use, LOAD_LAT=1
        v1 = 1'b1;
        op(4'd1, 4'd0, 4'd0, 3'b100, 32'h100, 32'h0, 32'h0, 4'd3, 1'b1);
        #1;
        tick();
        chk("l1_ld_exv", 32'(exv[0]), 32'd1);
        chk("l1_ld_flag", 32'(ldo[0]), 32'd1);
        chk("l1_ld_rd", 32'(rdco[0]), 32'd3);
        op(4'd2, 4'd3, 4'd0, 3'b110, 32'h200, 32'hBAD, 32'h0, 4'd11, 1'b0);
        #1;
        chk("l1_stl", 32'(stl[0]), 32'(IL));
        chk("l1_rdy", 32'(rdy[0]), 32'(!IL));
        tick();
        chk("l1_bub", 32'(exv[0]), 32'(!IL));
        op(4'd2, 4'd3, 4'd0, 3'b110, 32'h200, 32'h3333, 32'h0, 4'd11, 1'b0);
        #1;
        chk("l1_rdy2", 32'(rdy[0]), 32'd1);
        chk("l1_stl2", 32'(stl[0]), 32'd0);
        tick();
        chk("l1_dep_exv", 32'(exv[0]), 32'd1);
        chk("l1_dep_rn", rno[0], 32'h3333);
        chk("l1_dep_ld", 32'(ldo[0]), 32'd0);
        v1 = 1'b0;
        tick();

        // load-use, LOAD_LAT=3, r5 reader interleaved
        v3 = 1'b1;
        op(4'd1, 4'd0, 4'd0, 3'b100, 32'h100, 32'h0, 32'h0, 4'd3, 1'b1);
        #1;
        tick();
        chk("l3_ld", 32'(ldo[1]), 32'd1);
        op(4'd2, 4'd3, 4'd0, 3'b110, 32'h200, 32'h0A, 32'h0, 4'd11, 1'b0);
        #1;
        chk("l3_stl1", 32'(stl[1]), 32'(IL));
        chk("l3_rdy1", 32'(rdy[1]), 32'(!IL));
        tick();
        chk("l3_bub1", 32'(exv[1]), 32'(!IL));
        op(4'd5, 4'd0, 4'd0, 3'b100, 32'h5555_5555, 32'h0, 32'h0,
           4'd8, 1'b0);
        #1;
        chk("l3_r5_rdy", 32'(rdy[1]), 32'd1);
        tick();
        chk("l3_r5_exv", 32'(exv[1]), 32'd1);
        chk("l3_r5_rm", rmo[1], 32'h5555_5555);
        op(4'd2, 4'd3, 4'd0, 3'b110, 32'h200, 32'h0B, 32'h0, 4'd11, 1'b0);
        #1;
        chk("l3_stl3", 32'(stl[1]), 32'(IL));
        chk("l3_rdy3", 32'(rdy[1]), 32'(!IL));
        tick();
        chk("l3_bub3", 32'(exv[1]), 32'(!IL));
        #1;
        chk("l3_rdy4", 32'(rdy[1]), 32'd1);
        tick();
        chk("l3_dep_exv", 32'(exv[1]), 32'd1);
        chk("l3_dep_rn", rno[1], 32'h0B);
        v3 = 1'b0;
        tick();

        // flush during a load-use stall
        v3 = 1'b1;
        op(4'd1, 4'd0, 4'd0, 3'b100, 32'h100, 32'h0, 32'h0, 4'd3, 1'b1);
        #1;
        tick();
        op(4'd2, 4'd3, 4'd0, 3'b110, 32'h200, 32'h0C, 32'h0, 4'd11, 1'b0);
        #1;
        tick();
        flush = 1'b1;
        #1;
        tick();
        chk("fl_exv", 32'(exv[1]), 32'd0);
        flush = 1'b0;
        op(4'd2, 4'd3, 4'd0, 3'b110, 32'h200, 32'h0D, 32'h0, 4'd11, 1'b0);
        #1;
        chk("fl_rdy", 32'(rdy[1]), 32'd1);
        chk("fl_stl", 32'(stl[1]), 32'd0);
        tick();
        chk("fl_dep_exv", 32'(exv[1]), 32'd1);
        chk("fl_dep_rn", rno[1], 32'h0D);
        v3 = 1'b0;
        tick();

        // reset with slot valid and interlock waiting
        v3 = 1'b1;
        op(4'd1, 4'd0, 4'd0, 3'b100, 32'h100, 32'h0, 32'h0, 4'd3, 1'b1);
        #1;
        tick();
        op(4'd2, 4'd3, 4'd0, 3'b110, 32'h200, 32'h0E, 32'h0, 4'd11, 1'b0);
        #1;
        tick();
        op(4'd5, 4'd0, 4'd0, 3'b100, 32'h5555_5555, 32'h0, 32'h0,
           4'd8, 1'b0);
        #1;
        tick();
        chk("mr_pre_exv", 32'(exv[1]), 32'd1);
        rst = 1'b1;
        v3 = 1'b0;
        exr = 1'b0;
        #1;
        tick();
        chk("mr_exv", 32'(exv[1]), 32'd0);
        chk("mr_rm", rmo[1], 32'd0);
        chk("mr_rd", 32'(rdco[1]), 32'd0);
        chk("mr_rde", 32'(rdeo[1]), 32'd0);
        chk("mr_ctrl", ctlo[1], 32'd0);
        chk("mr_exv0", 32'(exv[0]), 32'd0);
        rst = 1'b0;
        exr = 1'b1;
        v3 = 1'b1;
        op(4'd2, 4'd3, 4'd0, 3'b110, 32'h200, 32'h0F, 32'h0, 4'd11, 1'b0);
        #1;
        chk("mr_rdy", 32'(rdy[1]), 32'd1);
        chk("mr_stl", 32'(stl[1]), 32'd0);
        tick();
        chk("mr_dep_exv", 32'(exv[1]), 32'd1);
        chk("mr_dep_rn", rno[1], 32'h0F);
        v3 = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
